// File: rtl/mult_add_arbiter_pkg.sv
// Shared constants for the mult_add arbiter: native DSP slice widths, the
// latency of the registered mult_add configuration and the index-width helper.
package mult_add_arbiter_pkg;

  localparam int DSP_A_WIDTH      = 25;
  localparam int DSP_B_WIDTH      = 18;
  localparam int DSP_C_WIDTH      = 48;
  localparam int DSP_P_WIDTH      = 48;
  localparam int DSP_MULT_LATENCY = 3;

  // Requester index width; never below one bit so a 2-way arbiter still has an index.
  function automatic int idx_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search starting at a rotating pointer; the pointer
// moves just past the last granted requester.
module rr_arbiter
  import mult_add_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [IDX_W-1:0]   ptr
);

  logic [IDX_W-1:0] cand;

  // rst gates the grant so req_ready drops the instant reset asserts.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_valid && en && !rst && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mult_add_arbiter.sv
// Shares one pipelined mult_add slice (p = a*b+c) among NUM_REQ requesters;
// a tag pipe matched to the slice latency routes each result back to its issuer.
module mult_add_arbiter
  import mult_add_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int A_DATA_WIDTH = DSP_A_WIDTH,
  parameter  int B_DATA_WIDTH = DSP_B_WIDTH,
  parameter  int C_DATA_WIDTH = DSP_C_WIDTH,
  parameter  int P_DATA_WIDTH = DSP_P_WIDTH,
  parameter  int MULT_LATENCY = DSP_MULT_LATENCY,
  localparam int IDX_W        = idx_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*A_DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0] req_c,
  output logic [A_DATA_WIDTH-1:0]         dsp_a,
  output logic [B_DATA_WIDTH-1:0]         dsp_b,
  output logic [C_DATA_WIDTH-1:0]         dsp_c,
  output logic                            dsp_valid,
  input  logic [P_DATA_WIDTH-1:0]         dsp_p,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [P_DATA_WIDTH-1:0]         rsp_p,
  output logic                            busy
);

  // Handshake: requester i transfers on a posedge where req_valid[i] & req_ready[i];
  // it holds valid and operands stable until then and may withdraw valid beforehand.
  // Responses carry no backpressure: rsp_valid is a one-cycle strobe.

  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        rr_ptr;
  logic [A_DATA_WIDTH-1:0] sel_a;
  logic [B_DATA_WIDTH-1:0] sel_b;
  logic [C_DATA_WIDTH-1:0] sel_c;
  logic [IDX_W-1:0]        dsp_idx;
  logic [MULT_LATENCY-1:0] tag_v;
  logic [IDX_W-1:0]        tag_idx [MULT_LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .grant       (req_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .ptr         (rr_ptr)
  );

  always_comb begin
    sel_a = req_a[grant_idx*A_DATA_WIDTH +: A_DATA_WIDTH];
    sel_b = req_b[grant_idx*B_DATA_WIDTH +: B_DATA_WIDTH];
    sel_c = req_c[grant_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  // Operand registers hold their last value when idle; only dsp_valid marks live work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_a     <= '0;
      dsp_b     <= '0;
      dsp_c     <= '0;
      dsp_valid <= 1'b0;
      dsp_idx   <= '0;
    end else begin
      dsp_valid <= grant_valid;
      if (grant_valid) begin
        dsp_a   <= sel_a;
        dsp_b   <= sel_b;
        dsp_c   <= sel_c;
        dsp_idx <= grant_idx;
      end
    end
  end

  // Tag stage k mirrors where the slice's result is after k+1 edges past dsp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k < MULT_LATENCY; k++) begin
        tag_idx[k] <= '0;
      end
    end else begin
      tag_v[0]   <= dsp_valid;
      tag_idx[0] <= dsp_idx;
      for (int k = 1; k < MULT_LATENCY; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_v[MULT_LATENCY-1]) begin
      rsp_valid[tag_idx[MULT_LATENCY-1]] = 1'b1;
    end
  end

  assign rsp_p = dsp_p;
  assign busy  = dsp_valid | (|tag_v);

endmodule

// File: tb/tb_mult_add_arbiter.sv
// Directed bench for mult_add_arbiter with a latency-3 stub mult_add slice
// and an in-order response scoreboard.
module tb_mult_add_arbiter;

  localparam int N   = 4;
  localparam int AW  = 25;
  localparam int BW  = 18;
  localparam int CW  = 48;
  localparam int PW  = 48;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N*CW-1:0] req_c;
  logic [AW-1:0]   dsp_a;
  logic [BW-1:0]   dsp_b;
  logic [CW-1:0]   dsp_c;
  logic            dsp_valid;
  logic [PW-1:0]   dsp_p;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_p;
  logic            busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [N+PW-1:0] exp_q[$];
  logic [N+PW-1:0] mon_ent;
  logic [PW-1:0]   t2_p [4] = '{48'd2, 48'd104, 48'd206, 48'd308};
  logic [N-1:0]    exp_g;

  // clock / reset
  always #5 clk = ~clk;

  mult_add_arbiter #(
    .NUM_REQ      (N),
    .A_DATA_WIDTH (AW),
    .B_DATA_WIDTH (BW),
    .C_DATA_WIDTH (CW),
    .P_DATA_WIDTH (PW),
    .MULT_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_c     (dsp_c),
    .dsp_valid (dsp_valid),
    .dsp_p     (dsp_p),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  // Stub slice: p = a*b+c with three register stages.
  logic signed [PW-1:0] s_pipe [LAT];
  always @(posedge clk) begin
    s_pipe[0] <= PW'($signed(dsp_a)) * PW'($signed(dsp_b)) + $signed(dsp_c);
    for (int k = 1; k < LAT; k++) s_pipe[k] <= s_pipe[k-1];
  end
  assign dsp_p = s_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else pass_cnt++;
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input longint c);
    req_a[i*AW +: AW] = AW'(a);
    req_b[i*BW +: BW] = BW'(b);
    req_c[i*CW +: CW] = CW'(c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  // scoreboard: responses must come back in issue order
  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        mon_ent = exp_q.pop_front();
        check("rsp_idx", 64'(rsp_valid), 64'(mon_ent[N+PW-1:PW]));
        check("rsp_p", 64'(rsp_p), 64'(mon_ent[PW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    #2;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_dsp_valid", 64'(dsp_valid), 64'(0));
    check("rst_dsp_abc", 64'(dsp_a | 25'(dsp_b) | 25'(dsp_c)), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, exact latency
    set_ops(2, 3, -4, 10);
    req_valid = 4'b0100;
    #1;
    check("t1_grant", 64'(req_ready), 64'(4'b0100));
    exp_q.push_back({4'b0100, 48'(-2)});
    step();
    req_valid = '0;
    check("t1_dsp_valid", 64'(dsp_valid), 64'(1));
    check("t1_dsp_a", 64'(dsp_a), 64'({25'(3)}));
    check("t1_dsp_b", 64'(dsp_b), 64'({18'(-4)}));
    check("t1_dsp_c", 64'(dsp_c), 64'({48'(10)}));
    step();
    check("t1_dsp_idle", 64'(dsp_valid), 64'(0));
    step();
    check("t1_early", 64'(rsp_valid), 64'(0));
    step();
    check("t1_rsp_time", 64'(rsp_valid), 64'(4'b0100));
    check("t1_rsp_p", 64'(rsp_p), 64'({48'(-2)}));
    wait_idle();

    // All four held: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, i + 1, 2, 100 * i);
    req_valid = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'(1 << (k % 4));
      check("t2_grant", 64'(req_ready), 64'(exp_g));
      exp_q.push_back({exp_g, t2_p[k % 4]});
      step();
    end
    req_valid = '0;
    wait_idle();

    // Requester 1 streaming, then 3 joins
    set_ops(1, -5, 7, 1);
    set_ops(3, 1000, -1000, 0);
    req_valid = 4'b0010;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t3_solo", 64'(req_ready), 64'(4'b0010));
      exp_q.push_back({4'b0010, 48'(-34)});
      step();
    end
    req_valid = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      check("t3_pair", 64'(req_ready), 64'(exp_g));
      exp_q.push_back({exp_g, (k % 2 == 0) ? 48'(-1000000) : 48'(-34)});
      step();
    end
    req_valid = '0;
    wait_idle();

    // en dropped with three operations in flight
    set_ops(0, 2, 3, 4);
    req_valid = 4'b0001;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t4_grant", 64'(req_ready), 64'(4'b0001));
      exp_q.push_back({4'b0001, 48'd10});
      step();
    end
    en = 1'b0;
    #1;
    check("t4_blocked", 64'(req_ready), 64'(0));
    step();
    check("t4_blocked", 64'(req_ready), 64'(0));
    step();
    check("t4_blocked", 64'(req_ready), 64'(0));
    check("t4_busy_mid", 64'(busy), 64'(1));
    step();
    check("t4_busy_last", 64'(busy), 64'(1));
    check("t4_last_rsp", 64'(rsp_valid), 64'(4'b0001));
    step();
    check("t4_busy_fall", 64'(busy), 64'(0));
    check("t4_rsp_done", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    en = 1'b1;

    // Asynchronous reset with two in flight: no responses may escape
    req_valid = 4'b0100;
    #1;
    check("t5_grant", 64'(req_ready), 64'(4'b0100));
    step();
    check("t5_grant", 64'(req_ready), 64'(4'b0100));
    step();
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_dsp_valid", 64'(dsp_valid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_ready", 64'(req_ready), 64'(0));
    check("t5_rst_dsp_a", 64'(dsp_a), 64'(0));
    check("t5_rst_rsp", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("t5_quiet", 64'(busy), 64'(0));
    req_valid = 4'b1010;
    #1;
    check("t5_first_grant", 64'(req_ready), 64'(4'b0010));
    exp_q.push_back({4'b0010, 48'(-34)});
    step();
    req_valid = '0;
    wait_idle();

    // Pointer wrap after requester 3, then a withdrawn request
    req_valid = 4'b1000;
    #1;
    check("t6_grant3", 64'(req_ready), 64'(4'b1000));
    exp_q.push_back({4'b1000, 48'(-1000000)});
    step();
    req_valid = 4'b1001;
    #1;
    check("t6_wrap", 64'(req_ready), 64'(4'b0001));
    exp_q.push_back({4'b0001, 48'd10});
    step();
    req_valid = 4'b0100;
    #1;
    check("t6_offer", 64'(req_ready), 64'(4'b0100));
    #2;
    req_valid = '0;
    step();
    check("t6_withdrawn", 64'(dsp_valid), 64'(0));
    wait_idle();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
